// File: rtl/vdp_host_bus_master.sv
// Single-beat valid/ready host initiator for the VDP CPU port.
// Produces setup/strobe/hold/recover timed csw_n/csr_n accesses.
module vdp_host_bus_master #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned PULSE_CYC   = 8,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned RECOVER_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [1:0] req_port,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] mode,
  output logic       csw_n,
  output logic       csr_n,
  output logic [7:0] cd_o,
  output logic       cd_oe,
  input  logic [7:0] cd_i
);

  localparam int unsigned MAX_SP =
    (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_HR =
    (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
  localparam int unsigned MAX_P =
    (MAX_SP > MAX_HR) ? MAX_SP : MAX_HR;
  localparam int unsigned CW =
    (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] LD_SETUP   = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_PULSE   = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD    = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_RECOVER = CW'(RECOVER_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q;
  logic          wr_q, wr_d;
  logic [1:0]    mode_d;
  logic          csw_n_d, csr_n_d;
  logic [7:0]    cd_o_d;
  logic          cd_oe_d;
  logic          rsp_valid_d;
  logic [7:0]    rsp_rdata_d;
  logic          cnt_zero;

  // run_q holds off acceptance until the first edge out of reset
  assign req_ready = run_q & (state_q == S_IDLE);
  assign cnt_zero  = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_zero ? cnt_q : cnt_q - CW'(1);
    wr_d        = wr_q;
    mode_d      = mode;
    csw_n_d     = csw_n;
    csr_n_d     = csr_n;
    cd_o_d      = cd_o;
    cd_oe_d     = cd_oe;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = S_SETUP;
          cnt_d   = LD_SETUP;
          wr_d    = req_wr;
          mode_d  = req_port;
          cd_o_d  = req_wr ? req_wdata : cd_o;
          cd_oe_d = req_wr;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_STROBE;
          cnt_d   = LD_PULSE;
          csw_n_d = ~wr_q;
          csr_n_d = wr_q;
        end
      end
      S_STROBE: begin
        if (cnt_zero) begin
          state_d = S_HOLD;
          cnt_d   = LD_HOLD;
          csw_n_d = 1'b1;
          csr_n_d = 1'b1;
          if (!wr_q) rsp_rdata_d = cd_i;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          state_d     = S_RECOVER;
          cnt_d       = LD_RECOVER;
          cd_oe_d     = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end
      S_RECOVER: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        csw_n_d = 1'b1;
        csr_n_d = 1'b1;
        cd_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      wr_q      <= 1'b0;
      mode      <= 2'd0;
      csw_n     <= 1'b1;
      csr_n     <= 1'b1;
      cd_o      <= 8'h00;
      cd_oe     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_q     <= 1'b1;
      wr_q      <= wr_d;
      mode      <= mode_d;
      csw_n     <= csw_n_d;
      csr_n     <= csr_n_d;
      cd_o      <= cd_o_d;
      cd_oe     <= cd_oe_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_vdp_host_bus_master.sv
// Directed bench for vdp_host_bus_master: default timing instance
// plus an all-ones timing instance, selected by sel.
module tb_vdp_host_bus_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_wr = 1'b0;
  logic [1:0] req_port = 2'd0;
  logic [7:0] req_wdata = 8'h00;
  logic [7:0] cd_i = 8'hFF;
  logic       sel = 1'b0;

  logic       rv0, rv1;
  logic       rdy0, rdy1, rsp0, rsp1;
  logic [7:0] rdat0, rdat1, cdo0, cdo1;
  logic [1:0] mode0, mode1;
  logic       csw0, csw1, csr0, csr1, oe0, oe1;

  logic       m_rdy, m_rsp, m_csw, m_csr, m_oe;
  logic [7:0] m_rdat, m_cdo;
  logic [1:0] m_mode;

  int checks = 0;
  int errors = 0;

  assign rv0 = req_valid & ~sel;
  assign rv1 = req_valid & sel;

  always #5 clk = ~clk;

  vdp_host_bus_master u0 (
    .clk(clk), .reset(reset),
    .req_valid(rv0), .req_ready(rdy0),
    .req_wr(req_wr), .req_port(req_port), .req_wdata(req_wdata),
    .rsp_valid(rsp0), .rsp_rdata(rdat0),
    .mode(mode0), .csw_n(csw0), .csr_n(csr0),
    .cd_o(cdo0), .cd_oe(oe0), .cd_i(cd_i)
  );

  vdp_host_bus_master #(
    .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .RECOVER_CYC(1)
  ) u1 (
    .clk(clk), .reset(reset),
    .req_valid(rv1), .req_ready(rdy1),
    .req_wr(req_wr), .req_port(req_port), .req_wdata(req_wdata),
    .rsp_valid(rsp1), .rsp_rdata(rdat1),
    .mode(mode1), .csw_n(csw1), .csr_n(csr1),
    .cd_o(cdo1), .cd_oe(oe1), .cd_i(cd_i)
  );

  always_comb begin
    m_rdy  = sel ? rdy1  : rdy0;
    m_rsp  = sel ? rsp1  : rsp0;
    m_rdat = sel ? rdat1 : rdat0;
    m_cdo  = sel ? cdo1  : cdo0;
    m_mode = sel ? mode1 : mode0;
    m_csw  = sel ? csw1  : csw0;
    m_csr  = sel ? csr1  : csr0;
    m_oe   = sel ? oe1   : oe0;
  end

  typedef struct {
    logic       wr;
    logic [1:0] port;
    logic [7:0] wdata;
    logic [7:0] rd;
    bit         poke;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timing(output int s, output int p,
                        output int h, output int r);
    if (sel) begin
      s = 1; p = 1; h = 1; r = 1;
    end else begin
      s = 2; p = 8; h = 2; r = 4;
    end
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!m_rdy && n < 60) begin
      tick();
      n++;
    end
    chk({nm, " ready_wait"}, 32'(m_rdy), 32'd1);
  endtask

  task automatic run_txn(input int id, input vec_t v);
    int s, p, h, r, t;
    logic        lo;
    logic [14:0] act, exp;
    timing(s, p, h, r);
    t = s + p + h + r;
    wait_ready($sformatf("txn%0d.%0d", sel, id));
    req_wr    = v.wr;
    req_port  = v.port;
    req_wdata = v.wdata;
    cd_i      = 8'hFF;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k <= t; k++) begin
      lo  = (k >= s) && (k < s + p);
      exp = {v.port, ~(v.wr & lo), ~(~v.wr & lo),
             v.wr && (k < s + p + h), k == s + p + h, k == t,
             v.wr ? v.wdata : 8'h00};
      act = {m_mode, m_csw, m_csr, m_oe, m_rsp, m_rdy,
             v.wr ? m_cdo : 8'h00};
      chk($sformatf("txn%0d.%0d k%0d bus", sel, id, k),
          32'(act), 32'(exp));
      if (k == s + p + h)
        chk($sformatf("txn%0d.%0d rdata", sel, id),
            32'(m_rdat), 32'(v.exp_rdata));
      cd_i      = ((k >= s) && (k < s + p)) ? v.rd : 8'hFF;
      req_valid = v.poke && (k == s);
      if (k < t) tick();
    end
    req_valid = 1'b0;
    cd_i      = 8'hFF;
    if (v.poke) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        chk($sformatf("txn%0d.%0d idle%0d", sel, id, k),
            32'({m_rdy, m_csw, m_csr, m_rsp}), 32'b1110);
      end
    end
  endtask

  task automatic run_b2b;
    int s, p, h, r, per, acc, nrsp, both;
    int edges[3];
    logic rb;
    timing(s, p, h, r);
    per  = s + p + h + r + 1;
    acc  = 0;
    nrsp = 0;
    both = 0;
    edges = '{-1000, -1000, -1000};
    wait_ready($sformatf("b2b%0d", sel));
    req_wr    = 1'b1;
    req_port  = 2'd2;
    req_wdata = 8'h55;
    req_valid = 1'b1;
    for (int c = 0; c < 3 * per + 6; c++) begin
      rb = m_rdy && req_valid;
      tick();
      if (rb) begin
        if (acc < 3) edges[acc] = c;
        acc++;
        if (acc == 3) req_valid = 1'b0;
      end
      if (m_rsp) nrsp++;
      if (!m_csw && !m_csr) both++;
    end
    req_valid = 1'b0;
    chk($sformatf("b2b%0d accepts", sel), 32'(acc), 32'd3);
    chk($sformatf("b2b%0d gap1", sel),
        32'(edges[1] - edges[0]), 32'(per));
    chk($sformatf("b2b%0d gap2", sel),
        32'(edges[2] - edges[0]), 32'(2 * per));
    chk($sformatf("b2b%0d rsp", sel), 32'(nrsp), 32'd3);
    chk($sformatf("b2b%0d both_low", sel), 32'(both), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nrsp;
    vec_t rv;

    tbl[0] = '{1'b1, 2'd1, 8'h8F, 8'hFF, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 2'd0, 8'h00, 8'h5A, 1'b0, 8'h5A};
    tbl[2] = '{1'b1, 2'd2, 8'h3C, 8'hFF, 1'b0, 8'h5A};
    tbl[3] = '{1'b0, 2'd3, 8'h00, 8'hA5, 1'b0, 8'hA5};
    tbl[4] = '{1'b1, 2'd3, 8'h00, 8'hFF, 1'b1, 8'hA5};
    tbl[5] = '{1'b0, 2'd2, 8'h00, 8'h00, 1'b1, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_vals",
        32'({m_mode, m_csw, m_csr, m_oe, m_cdo, m_rsp, m_rdat, m_rdy}),
        32'({2'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0}));
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("ready_after_reset", 32'(m_rdy), 32'd1);

    for (int i = 0; i < 6; i++) run_txn(i, tbl[i]);
    run_b2b();

    // asynchronous abort in the middle of a write strobe
    wait_ready("abort");
    req_wr    = 1'b1;
    req_port  = 2'd1;
    req_wdata = 8'h8F;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    chk("abort pre_csw", 32'({m_csw, m_oe}), 32'b01);
    #2;
    reset = 1'b1;
    #1;
    chk("abort now",
        32'({m_csw, m_csr, m_oe, m_rsp, m_rdy, m_mode}),
        32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}));
    req_valid = 1'b1;
    nrsp = 0;
    repeat (3) begin
      tick();
      if (m_rsp || !m_csw || !m_csr) nrsp++;
    end
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      tick();
      if (m_rsp || !m_csw || !m_csr) nrsp++;
    end
    chk("abort no_activity", 32'(nrsp), 32'd0);
    rv = '{1'b0, 2'd1, 8'h00, 8'hC3, 1'b0, 8'hC3};
    run_txn(9, rv);

    sel = 1'b1;
    for (int i = 0; i < 6; i++) run_txn(i, tbl[i]);
    run_b2b();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
